// File: rtl/alu_exec_mc_if.sv
// alu_exec_mc_if: request/response handshake bundle for alu_exec_mc
interface alu_exec_mc_if #(
  parameter int N = 64
);
  logic in_valid;
  logic in_ready;
  logic [1:0] aluop;
  logic [10:0] funct;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] result;
  logic zero;
  modport master (
    output in_valid, aluop, funct, a, b, out_ready,
    input in_ready, out_valid, result, zero
  );
  modport slave (
    input in_valid, aluop, funct, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_mc.sv
// alu_exec_mc: multi-cycle LEGv8 ALU (IDLE/EXEC/DONE) with valid/ready handshake; MUL built only when ALU_MUL_EN is defined
module alu_exec_mc #(
  parameter int N = 64
) (
  input logic clk,
  input logic reset,
  alu_exec_mc_if.slave bus
);
`ifdef ALU_MUL_EN
  localparam int CW = $clog2(N + 1);
`else
  localparam int CW = 2;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_PASS, OP_MOVZ, OP_MUL, OP_UNK} op_e;
  state_e state_q, state_d;
  op_e op;
  logic [N-1:0] res_q, res_d, alu;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] hw;
`ifdef ALU_MUL_EN
  logic [N-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  logic mul_q, mul_d;
`endif
  assign hw = bus.funct[1:0];
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.result = res_q;
  assign bus.zero = res_q == '0;
  // decode the main-decoder class and funct field into one operation
  always_comb begin
    op = OP_UNK;
    if (bus.aluop == 2'b00) op = OP_ADD;
    else if (bus.aluop == 2'b01) op = OP_PASS;
    else if (bus.aluop == 2'b10) begin
      if (bus.funct == 11'b10001011000) op = OP_ADD;
      else if (bus.funct == 11'b11001011000) op = OP_SUB;
      else if (bus.funct == 11'b10001010000) op = OP_AND;
      else if (bus.funct == 11'b10101010000) op = OP_ORR;
`ifdef ALU_MUL_EN
      else if (bus.funct == 11'b10011011000) op = OP_MUL;
`endif
    end else begin
      if (bus.funct[10:1] == 10'b1001000100) op = OP_ADD;
      else if (bus.funct[10:1] == 10'b1101000100) op = OP_SUB;
      else if (bus.funct[10:1] == 10'b1001001000) op = OP_AND;
      else if (bus.funct[10:1] == 10'b1011001000) op = OP_ORR;
      else if (bus.funct[10:2] == 9'b110100101) op = OP_MOVZ;
    end
  end
  // single-step result; MOVZ starts from B, MUL accumulator starts from 0
  always_comb begin
    alu = op == OP_ADD ? bus.a + bus.b :
          op == OP_SUB ? bus.a - bus.b :
          op == OP_AND ? bus.a & bus.b :
          op == OP_ORR ? bus.a | bus.b :
          op == OP_PASS || op == OP_MOVZ ? bus.b : '0;
  end
  // next state: accept in IDLE, iterate in EXEC, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    cnt_d = cnt_q;
`ifdef ALU_MUL_EN
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    mul_d = mul_q;
`endif
    case (state_q)
      IDLE: if (bus.in_valid) begin
        res_d = alu;
        state_d = DONE;
        if (op == OP_MOVZ && hw != 2'd0) begin
          state_d = EXEC;
          cnt_d = CW'(hw);
        end
`ifdef ALU_MUL_EN
        mul_d = op == OP_MUL;
        mcand_d = bus.a;
        mplier_d = bus.b;
        if (op == OP_MUL) begin
          state_d = EXEC;
          cnt_d = CW'(N);
        end
`endif
      end
      EXEC: begin
`ifdef ALU_MUL_EN
        res_d = mul_q ? res_q + (mplier_q[0] ? mcand_q : '0) : res_q << 16;
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`else
        res_d = res_q << 16;
`endif
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q <= '0;
      cnt_q <= '0;
`ifdef ALU_MUL_EN
      mcand_q <= '0;
      mplier_q <= '0;
      mul_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
`ifdef ALU_MUL_EN
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      mul_q <= mul_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_exec_mc.sv
// tb_alu_exec_mc: directed tests for alu_exec_mc (N=64); MUL expectations follow ALU_MUL_EN
module tb_alu_exec_mc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic [1:0] op;
    logic [10:0] f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
  } vec_t;
  alu_exec_mc_if #(.N(64)) bus ();
  alu_exec_mc #(.N(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // present one request at a negedge in IDLE; returns at accept+1 with inputs scrambled
  task automatic send(input logic [1:0] op, input logic [10:0] f, input logic [63:0] a, input logic [63:0] b);
    bus.aluop = op;
    bus.funct = f;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.aluop = ~op;
    bus.funct = ~f;
    bus.a = ~a;
    bus.b = ~b;
  endtask
  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", bus.zero); end
  endtask
  task automatic test_single_ops();
    vec_t v [14];
    v = '{
      '{2'b00, 11'b00000000000, 64'd100, 64'd28, 64'd128},
      '{2'b01, 11'b11111111111, 64'd5, 64'd0, 64'd0},
      '{2'b01, 11'b00000000000, 64'd5, 64'h1234, 64'h1234},
      '{2'b10, 11'b10001011000, 64'd5, 64'd7, 64'd12},
      '{2'b10, 11'b11001011000, 64'd3, 64'd5, 64'hFFFFFFFFFFFFFFFE},
      '{2'b10, 11'b10001010000, 64'hF0F0, 64'hFF00, 64'hF000},
      '{2'b10, 11'b10101010000, 64'hF0, 64'h0F, 64'hFF},
      '{2'b11, 11'b10010001000, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0},
      '{2'b11, 11'b11010001000, 64'd9, 64'd9, 64'd0},
      '{2'b11, 11'b10010010000, 64'hFF, 64'h3C, 64'h3C},
      '{2'b11, 11'b10110010001, 64'h100, 64'h1, 64'h101},
      '{2'b10, 11'b00000000000, 64'd5, 64'd7, 64'd0},
      '{2'b11, 11'b11111111111, 64'd5, 64'd7, 64'd0},
      '{2'b11, 11'b11010010100, 64'd0, 64'h1234, 64'h1234}
    };
    foreach (v[i]) begin
      send(v[i].op, v[i].f, v[i].a, v[i].b);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL op%0d_latency out_valid got=%b want=1", i, bus.out_valid); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL op%0d_in_ready got=%b want=0", i, bus.in_ready); end
      total++; if (bus.result !== v[i].r) begin bad++; $display("FAIL op%0d_result got=%h want=%h", i, bus.result, v[i].r); end
      total++; if (bus.zero !== (v[i].r == 64'd0)) begin bad++; $display("FAIL op%0d_zero got=%b want=%b", i, bus.zero, v[i].r == 64'd0); end
      pop();
    end
  endtask
  task automatic test_movz();
    send(2'b11, 11'b11010010111, 64'd0, 64'hBEEF);
    for (int k = 1; k <= 3; k++) begin
      total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL movz3_busy_%0d got rdy=%b vld=%b want 0 0", k, bus.in_ready, bus.out_valid); end
      @(negedge clk);
    end
    total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL movz3_done got vld=%b rdy=%b want 1 0", bus.out_valid, bus.in_ready); end
    total++; if (bus.result !== 64'hBEEF000000000000) begin bad++; $display("FAIL movz3_result got=%h want=beef000000000000", bus.result); end
    pop();
    send(2'b11, 11'b11010010101, 64'd0, 64'hBEEF);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL movz1_early got=%b want=0", bus.out_valid); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 64'hBEEF0000) begin bad++; $display("FAIL movz1_result got vld=%b res=%h want 1 beef0000", bus.out_valid, bus.result); end
    pop();
    send(2'b11, 11'b11010010111, 64'd0, 64'h0001000000000000);
    repeat (3) @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 64'd0 || bus.zero !== 1'b1) begin bad++; $display("FAIL movz_discard got vld=%b res=%h zero=%b want 1 0 1", bus.out_valid, bus.result, bus.zero); end
    pop();
  endtask
  task automatic test_mul();
    int k;
`ifdef ALU_MUL_EN
    send(2'b10, 11'b10011011000, 64'd3, 64'hFFFFFFFFFFFFFFFF);
    k = 1;
    while (bus.out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++; if (k != 65) begin bad++; $display("FAIL mul_latency got=%0d want=65", k); end
    total++; if (bus.result !== 64'hFFFFFFFFFFFFFFFD) begin bad++; $display("FAIL mul_result got=%h want=fffffffffffffffd", bus.result); end
    pop();
    send(2'b10, 11'b10011011000, 64'd7, 64'd6);
    k = 1;
    while (bus.out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++; if (k != 65 || bus.result !== 64'd42) begin bad++; $display("FAIL mul_7x6 got lat=%0d res=%h want 65 2a", k, bus.result); end
    pop();
`else
    k = 0;
    send(2'b10, 11'b10011011000, 64'd3, 64'hFFFFFFFFFFFFFFFF);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mul_off_latency got=%b want=1 (k=%0d)", bus.out_valid, k); end
    total++; if (bus.result !== 64'd0 || bus.zero !== 1'b1) begin bad++; $display("FAIL mul_off_result got res=%h zero=%b want 0 1", bus.result, bus.zero); end
    pop();
`endif
  endtask
  task automatic test_hold();
    send(2'b10, 11'b10101010000, 64'hF0, 64'h0F);
    bus.aluop = 2'b00;
    bus.a = 64'd1;
    bus.b = 64'd1;
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.result !== 64'hFF || bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_%0d got vld=%b res=%h rdy=%b want 1 ff 0", k, bus.out_valid, bus.result, bus.in_ready); end
      if (k == 4) bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'hFF) begin bad++; $display("FAIL hold_release got rdy=%b vld=%b res=%h want 1 0 ff", bus.in_ready, bus.out_valid, bus.result); end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_reset_mid();
    send(2'b10, 11'b10011011000, 64'd3, 64'hFFFFFFFFFFFFFFFF);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_state got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    total++; if (bus.result !== 64'd0 || bus.zero !== 1'b1) begin bad++; $display("FAIL rstmid_result got res=%h zero=%b want 0 1", bus.result, bus.zero); end
    send(2'b10, 11'b10001011000, 64'd1, 64'd1);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 64'd2) begin bad++; $display("FAIL rstmid_add got vld=%b res=%h want 1 2", bus.out_valid, bus.result); end
    bus.out_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.aluop = 2'b00;
    bus.a = 64'd4;
    bus.b = 64'd5;
    bus.in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 64'd0) begin bad++; $display("FAIL rst_priority got vld=%b rdy=%b res=%h want 0 1 0", bus.out_valid, bus.in_ready, bus.result); end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.aluop = 2'b00;
    bus.funct = 11'd0;
    bus.a = 64'd0;
    bus.b = 64'd0;
    test_reset();
    test_single_ops();
    test_movz();
    test_mul();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_mc.md
ALU_EXEC_MC -- requirements
Module: alu_exec_mc

Interface
REQ-001 SHALL have parameter N, default 64, meaning operand/result width in bits (legal range 16..64).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port aluop  input  2  main-decoder class: 00 LDUR/STUR, 01 CBZ, 10 R-type, 11 I/IM-type.
REQ-007 SHALL have port funct  input  11  instruction[31:21].
REQ-008 SHALL have ports a, b  input  N  operands A and B.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  N  operation result.
REQ-012 SHALL have port zero  output  1  result equals 0.

Function
REQ-013 Decode SHALL be: aluop 00 -> A+B; aluop 01 -> pass B; aluop 10 with funct 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR, 10011011000 MUL; aluop 11 with funct[10:1] 1001000100 ADDI, 1101000100 SUBI, 1001001000 ANDI, 1011001000 ORRI, funct[10:2] 110100101 MOVZ (hw = funct[1:0]); any other combination -> unknown.
REQ-014 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b, aluop and funct SHALL be captured then and ignored afterwards.
REQ-015 FSM states SHALL be IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE -> DONE on acceptance of ADD/SUB/AND/ORR/immediate forms/pass-B/unknown; IDLE -> EXEC on acceptance of MOVZ with hw>0 or MUL; MOVZ with hw=0 SHALL go straight to DONE.
REQ-017 Single-step operations SHALL present out_valid=1 in the cycle after acceptance (latency 1).
REQ-018 MOVZ SHALL shift B left 16 bits per EXEC cycle for hw cycles (out_valid at acceptance+1+hw); bits shifted beyond bit N-1 are discarded, so hw*16 >= N yields 0.
REQ-019 MUL SHALL be iterative shift-add, one multiplier bit per EXEC cycle, exactly N EXEC cycles (out_valid at acceptance+1+N); result = low N bits of A*B.
REQ-020 Add/subtract SHALL be modulo 2^N; no carry/overflow outputs.
REQ-021 Unknown operations SHALL produce result 0.
REQ-022 In DONE, out_valid=1 and result/zero SHALL stay stable until out_ready=1; DONE -> IDLE on that edge.
REQ-023 in_valid SHALL be ignored outside IDLE; no overlap of requests (the accept-on-DONE-exit case waits one IDLE cycle).
REQ-024 zero SHALL equal (result == 0) at all times.

Reset
REQ-025 reset=0 at a rising edge SHALL force IDLE, out_valid=0, result=0, zero=1, in_ready=1 on the next cycle, discarding any in-flight operation including mid-EXEC.
REQ-026 reset SHALL take priority over every handshake event in the same cycle.

Configuration
REQ-027 Macro ALU_MUL_EN defined: MUL decoded and executed per REQ-019.
REQ-028 ALU_MUL_EN undefined: MUL funct SHALL decode as unknown (result 0, latency 1) and no multiplier datapath or counter bits for it SHALL be synthesised.

Verification (N=64)
REQ-029 ADD aluop 10, a=5, b=7 -> out_valid at accept+1, result=12, zero=0.
REQ-030 SUBI aluop 11, funct 11010001000, a=9, b=9 -> result=0, zero=1 at accept+1.
REQ-031 MOVZ aluop 11, funct 11010010111, b=0xBEEF -> result=0xBEEF000000000000 at accept+4; in_ready=0 during accept+1..accept+4.
REQ-032 ALU_MUL_EN defined: MUL a=3, b=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFD at accept+65; undefined: result=0 at accept+1.
REQ-033 ORR a=0xF0, b=0x0F with out_ready=0 for 3 cycles -> result 0xFF held, out_valid=1 for 4 cycles, in_valid pulses ignored until return to IDLE.
REQ-034 reset=0 at accept+10 of a MUL -> next cycle out_valid=0, in_ready=1, result=0, zero=1; a following ADD 1+1 returns 2.
